// File: rtl/ufifo_thresh.sv
// ---------------------------------------------------------------------------
// ufifo_thresh
//   First-word-fall-through UART FIFO holding the full 2^LGFLEN entries,
//   with an occupancy count, a programmable threshold interrupt and sticky
//   overflow/underflow errors. It serves both the RX path (RXFIFO=1, count
//   reports entries held) and the TX path (RXFIFO=0, count reports free
//   slots).
//
// Ports
//   i_clk, i_rst      clock; asynchronous active-high reset
//   i_wr, i_data      push request and write data
//   i_rd              pop request
//   o_data            oldest entry (valid while o_empty_n)
//   o_empty_n, o_full occupancy flags
//   o_fill            entries held, 0..FLEN
//   i_thresh, o_irq   threshold interrupt (count >= i_thresh, 0 disables)
//   i_flush           synchronous discard of all contents
//   i_clr_err         clear the sticky error bits
//   o_ovfl, o_unfl    sticky refused-push / refused-pop flags
//   o_err             o_ovfl | o_unfl
//   o_status          {LGFLEN[3:0], count[9:0], half, ready}
// ---------------------------------------------------------------------------
module ufifo_thresh #(
   parameter int BW     = 8,
   parameter int LGFLEN = 4,
   parameter bit RXFIFO = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr,
   input  logic [BW-1:0]     i_data,
   input  logic              i_rd,
   output logic [BW-1:0]     o_data,
   output logic              o_empty_n,
   output logic              o_full,
   output logic [LGFLEN:0]   o_fill,
   input  logic [LGFLEN:0]   i_thresh,
   output logic              o_irq,
   input  logic              i_flush,
   input  logic              i_clr_err,
   output logic              o_ovfl,
   output logic              o_unfl,
   output logic              o_err,
   output logic [15:0]       o_status
);

   localparam int FLEN = 1 << LGFLEN;
   localparam logic [LGFLEN:0] FLEN_W = (LGFLEN+1)'(FLEN);

   logic [BW-1:0]   r_mem [FLEN];
   logic [LGFLEN:0] r_wptr, r_rptr, r_fill;
   logic            r_empty_n, r_full, r_ovfl, r_unfl, r_irq;

   logic            w_push, w_pop, w_ovfl_ev, w_unfl_ev;
   logic [LGFLEN:0] w_wptr_nxt, w_rptr_nxt, w_fill_nxt, w_free;
   logic [9:0]      w_count;
   logic            w_half, w_ready;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   // a write when i_rd is high. Flush suppresses both and any error event.
   assign w_push    = i_wr && (!r_full || i_rd) && !i_flush;
   assign w_pop     = i_rd && r_empty_n && !i_flush;
   assign w_ovfl_ev = i_wr && r_full && !i_rd && !i_flush;
   assign w_unfl_ev = i_rd && !r_empty_n && !i_flush;

   always_comb begin
      w_wptr_nxt = r_wptr;
      w_rptr_nxt = r_rptr;
      w_fill_nxt = r_fill;
      if (i_flush) begin
         w_rptr_nxt = r_wptr;
         w_fill_nxt = '0;
      end else begin
         if (w_push) w_wptr_nxt = r_wptr + 1'b1;
         if (w_pop)  w_rptr_nxt = r_rptr + 1'b1;
         if (w_push && !w_pop)      w_fill_nxt = r_fill + 1'b1;
         else if (w_pop && !w_push) w_fill_nxt = r_fill - 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_fill    <= '0;
         r_empty_n <= 1'b0;
         r_full    <= 1'b0;
         r_ovfl    <= 1'b0;
         r_unfl    <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_wptr    <= w_wptr_nxt;
         r_rptr    <= w_rptr_nxt;
         r_fill    <= w_fill_nxt;
         // Full/empty come from the next pointers: full when the wrap bits
         // differ and the addresses match.
         r_empty_n <= (w_wptr_nxt != w_rptr_nxt);
         r_full    <= (w_wptr_nxt[LGFLEN] != w_rptr_nxt[LGFLEN]) &&
                      (w_wptr_nxt[LGFLEN-1:0] == w_rptr_nxt[LGFLEN-1:0]);
         // An error event in the same cycle as a clear keeps the bit set.
         if (w_ovfl_ev)     r_ovfl <= 1'b1;
         else if (i_clr_err) r_ovfl <= 1'b0;
         if (w_unfl_ev)     r_unfl <= 1'b1;
         else if (i_clr_err) r_unfl <= 1'b0;
         r_irq     <= (w_count >= 10'(i_thresh)) && (i_thresh != '0);
      end
   end

   // Storage carries no reset; only pointers decide what is valid.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr[LGFLEN-1:0]] <= i_data;
   end

   assign w_free  = FLEN_W - r_fill;
   assign w_count = RXFIFO ? 10'(r_fill) : 10'(w_free);
   assign w_half  = w_count[LGFLEN-1] | w_count[LGFLEN];
   assign w_ready = RXFIFO ? r_empty_n : !r_full;

   assign o_data    = r_mem[r_rptr[LGFLEN-1:0]];
   assign o_empty_n = r_empty_n;
   assign o_full    = r_full;
   assign o_fill    = r_fill;
   assign o_irq     = r_irq;
   assign o_ovfl    = r_ovfl;
   assign o_unfl    = r_unfl;
   assign o_err     = r_ovfl | r_unfl;
   assign o_status  = {4'(LGFLEN), w_count, w_half, w_ready};

endmodule

// File: tb/tb_ufifo_thresh.sv
// ---------------------------------------------------------------------------
// tb_ufifo_thresh
//   Drives one RX-mode and one TX-mode ufifo_thresh (BW=8, LGFLEN=4) with
//   shared stimulus and compares every cycle against a queue-based model.
// ---------------------------------------------------------------------------
module tb_ufifo_thresh;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       i_rst, i_wr, i_rd, i_flush, i_clr_err;
   logic [7:0] i_data;
   logic [4:0] i_thresh;

   logic [7:0]  rx_data, tx_data;
   logic        rx_empty_n, rx_full, rx_irq, rx_ovfl, rx_unfl, rx_err;
   logic        tx_empty_n, tx_full, tx_irq, tx_ovfl, tx_unfl, tx_err;
   logic [4:0]  rx_fill, tx_fill;
   logic [15:0] rx_status, tx_status;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0] q[$];
   bit         m_ovfl, m_unfl, m_irq_rx, m_irq_tx;

   always #5 clk = ~clk;

   ufifo_thresh #(.BW(8), .LGFLEN(4), .RXFIFO(1'b1)) dut_rx (
      .i_clk(clk), .i_rst(i_rst), .i_wr(i_wr), .i_data(i_data), .i_rd(i_rd),
      .o_data(rx_data), .o_empty_n(rx_empty_n), .o_full(rx_full),
      .o_fill(rx_fill), .i_thresh(i_thresh), .o_irq(rx_irq),
      .i_flush(i_flush), .i_clr_err(i_clr_err), .o_ovfl(rx_ovfl),
      .o_unfl(rx_unfl), .o_err(rx_err), .o_status(rx_status));

   ufifo_thresh #(.BW(8), .LGFLEN(4), .RXFIFO(1'b0)) dut_tx (
      .i_clk(clk), .i_rst(i_rst), .i_wr(i_wr), .i_data(i_data), .i_rd(i_rd),
      .o_data(tx_data), .o_empty_n(tx_empty_n), .o_full(tx_full),
      .o_fill(tx_fill), .i_thresh(i_thresh), .o_irq(tx_irq),
      .i_flush(i_flush), .i_clr_err(i_clr_err), .o_ovfl(tx_ovfl),
      .o_unfl(tx_unfl), .o_err(tx_err), .o_status(tx_status));

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      int n, fr;
      logic [15:0] e_rx, e_tx;
      n  = q.size();
      fr = DEPTH - n;
      e_rx = {4'd4, 10'(n),  (n  >= 8), (n > 0)};
      e_tx = {4'd4, 10'(fr), (fr >= 8), (n < DEPTH)};
      check("rx_fill",    32'(rx_fill),    32'(n));
      check("tx_fill",    32'(tx_fill),    32'(n));
      check("rx_empty_n", 32'(rx_empty_n), 32'(n > 0));
      check("tx_empty_n", 32'(tx_empty_n), 32'(n > 0));
      check("rx_full",    32'(rx_full),    32'(n == DEPTH));
      check("tx_full",    32'(tx_full),    32'(n == DEPTH));
      check("rx_ovfl",    32'(rx_ovfl),    32'(m_ovfl));
      check("tx_ovfl",    32'(tx_ovfl),    32'(m_ovfl));
      check("rx_unfl",    32'(rx_unfl),    32'(m_unfl));
      check("tx_unfl",    32'(tx_unfl),    32'(m_unfl));
      check("rx_err",     32'(rx_err),     32'(m_ovfl | m_unfl));
      check("tx_err",     32'(tx_err),     32'(m_ovfl | m_unfl));
      check("rx_irq",     32'(rx_irq),     32'(m_irq_rx));
      check("tx_irq",     32'(tx_irq),     32'(m_irq_tx));
      check("rx_status",  32'(rx_status),  32'(e_rx));
      check("tx_status",  32'(tx_status),  32'(e_tx));
      if (n > 0) begin
         check("rx_data", 32'(rx_data), 32'(q[0]));
         check("tx_data", 32'(tx_data), 32'(q[0]));
      end
   endtask

   // One clock: apply inputs, advance the model across the edge, compare.
   task automatic step(input bit wr, input logic [7:0] d, input bit rd,
                       input bit fl, input bit clr, input logic [4:0] th);
      int  n;
      bit  ev_o, ev_u;
      i_wr = wr; i_data = d; i_rd = rd; i_flush = fl; i_clr_err = clr;
      i_thresh = th;
      @(posedge clk);
      n    = q.size();
      m_irq_rx = (th != 0) && (n >= int'(th));
      m_irq_tx = (th != 0) && ((DEPTH - n) >= int'(th));
      ev_o = 0;
      ev_u = 0;
      if (fl) q.delete();
      else begin
         ev_o = wr && (n == DEPTH) && !rd;
         ev_u = rd && (n == 0);
         if (rd && n > 0) void'(q.pop_front());
         if (wr && (n < DEPTH || rd)) q.push_back(d);
      end
      if (ev_o) m_ovfl = 1; else if (clr) m_ovfl = 0;
      if (ev_u) m_unfl = 1; else if (clr) m_unfl = 0;
      #1;
      compare_all();
   endtask

   task automatic model_reset();
      q.delete();
      m_ovfl = 0; m_unfl = 0; m_irq_rx = 0; m_irq_tx = 0;
   endtask

   initial begin
      int pw, pr;
      i_rst = 1; i_wr = 0; i_rd = 0; i_flush = 0; i_clr_err = 0;
      i_data = 0; i_thresh = 0;
      model_reset();
      #12 i_rst = 0;
      #1 compare_all();

      // Fill to 16 then refuse a push, accept push+pop, clear error
      for (int i = 0; i < 16; i++) step(1, (i == 15) ? 8'h10 : 8'(8'h11 + i), 0, 0, 0, 0);
      step(1, 8'hAA, 0, 0, 0, 0);
      step(1, 8'hBB, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 0);

      // Underflow with a simultaneous accepted write into empty FIFO
      step(1, 8'h5A, 1, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0);

      // Threshold interrupt, then disable it
      for (int i = 0; i < 4; i++) step(1, 8'(8'h30 + i), 0, 0, 0, 5'd4);
      step(0, 0, 0, 0, 0, 5'd4);
      step(0, 0, 0, 0, 0, 5'd0);
      step(0, 0, 0, 0, 0, 5'd0);

      // Five held, then flush with a coincident write
      step(1, 8'h34, 0, 0, 0, 0);
      step(1, 8'h35, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Overflow sticky across a flush
      for (int i = 0; i < 17; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0);
      step(1, 8'h77, 0, 1, 0, 0);
      step(1, 8'h78, 1, 0, 1, 0);

      // Asynchronous reset in the middle of a burst
      for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 0);
      #3 i_rst = 1;
      #1 model_reset();
      compare_all();
      i_wr = 0;
      @(posedge clk);
      #1 i_rst = 0;
      compare_all();
      for (int i = 0; i < 3; i++) step(1, 8'(8'h70 + i), 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);

      // Randomised phases with different push/pop bias
      for (int ph = 0; ph < 4; ph++) begin
         pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 55;
         pr = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
         for (int c = 0; c < 250; c++)
            step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                 5'($urandom_range(0, 16)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
